// File: rtl/mem_ops_defs.sv
// Shared encodings for the load/store sequencer:
// opcodes, FSM states, lane widths and alignment helpers.
package mem_ops_defs;

  localparam int BYTE_W = 8;
  localparam int HALF_W = 16;
  localparam int WORD_W = 32;

  typedef enum logic [2:0] {
    OP_LW  = 3'b000,
    OP_LH  = 3'b001,
    OP_LHU = 3'b010,
    OP_LB  = 3'b011,
    OP_LBU = 3'b100,
    OP_SW  = 3'b101,
    OP_SH  = 3'b110,
    OP_SB  = 3'b111
  } op_e;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_READ  = 3'd1,
    ST_MERGE = 3'd2,
    ST_WRITE = 3'd3,
    ST_DONE  = 3'd4
  } state_e;

  function automatic logic is_store(op_e op);
    return (op == OP_SW) || (op == OP_SH) || (op == OP_SB);
  endfunction

  function automatic logic misaligned(op_e op, logic [1:0] off);
    logic bad;
    bad = 1'b0;
    if ((op == OP_LW) || (op == OP_SW))
      bad = (off != 2'b00);
    else if ((op == OP_LH) || (op == OP_LHU) || (op == OP_SH))
      bad = off[0];
    return bad;
  endfunction

endpackage

// File: rtl/byte_lane_unit.sv
// Little-endian lane extraction with sign/zero extension for loads,
// and lane replacement of a fetched word for sub-word stores.
module byte_lane_unit
  import mem_ops_defs::*;
(
  input  op_e               op,
  input  logic [1:0]        off,
  input  logic [WORD_W-1:0] rdata,
  input  logic [HALF_W-1:0] wdata,
  output logic [WORD_W-1:0] ldata,
  output logic [WORD_W-1:0] mdata
);

  logic [BYTE_W-1:0] lane_b;
  logic [HALF_W-1:0] lane_h;

  always_comb begin
    lane_b = rdata[{off, 3'b000} +: BYTE_W];
    lane_h = off[1] ? rdata[31:16] : rdata[15:0];
  end

  always_comb begin
    ldata = rdata;
    unique case (op)
      OP_LH:   ldata = {{HALF_W{lane_h[HALF_W-1]}}, lane_h};
      OP_LHU:  ldata = {{HALF_W{1'b0}}, lane_h};
      OP_LB:   ldata = {{(WORD_W-BYTE_W){lane_b[BYTE_W-1]}}, lane_b};
      OP_LBU:  ldata = {{(WORD_W-BYTE_W){1'b0}}, lane_b};
      default: ldata = rdata;
    endcase
  end

  always_comb begin
    mdata = rdata;
    if (op == OP_SB)
      mdata[{off, 3'b000} +: BYTE_W] = wdata[BYTE_W-1:0];
    else if (op == OP_SH)
      mdata[{off[1], 4'b0000} +: HALF_W] = wdata;
  end

endmodule

// File: rtl/mem_access_unit.sv
// Load/store sequencer in front of a word-only, 1-cycle-latency DataMem.
// Sub-word stores are done as read-modify-write through byte_lane_unit.
module mem_access_unit
  import mem_ops_defs::*;
#(
  parameter int ADDR_WIDTH = 10
) (
  input  logic                  Clock,
  input  logic                  Reset,
  input  logic                  Req,
  input  logic [2:0]            Op,
  input  logic [ADDR_WIDTH+1:0] ByteAddr,
  input  logic [WORD_W-1:0]     StoreData,
  output logic [WORD_W-1:0]     LoadData,
  output logic                  Busy,
  output logic                  Done,
  output logic                  Error,
  output logic [ADDR_WIDTH-1:0] MemAddress,
  output logic [WORD_W-1:0]     MemWriteData,
  output logic                  MemRead,
  output logic                  MemWrite,
  input  logic [WORD_W-1:0]     MemReadData
);

  state_e                state;
  state_e                next;
  op_e                   op_q;
  logic [ADDR_WIDTH+1:0] addr_q;
  logic [WORD_W-1:0]     data_q;
  logic [WORD_W-1:0]     ld_ext;
  logic [WORD_W-1:0]     merged;
  logic                  accept;
  logic                  bad;

  assign accept = (state == ST_IDLE) && Req;
  assign bad    = misaligned(op_e'(Op), ByteAddr[1:0]);

  byte_lane_unit u_lanes (
    .op    (op_q),
    .off   (addr_q[1:0]),
    .rdata (MemReadData),
    .wdata (data_q[HALF_W-1:0]),
    .ldata (ld_ext),
    .mdata (merged)
  );

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) state <= ST_IDLE;
    else       state <= next;
  end

  always_comb begin
    next = state;
    unique case (state)
      ST_IDLE: begin
        if (Req) begin
          if (bad)                     next = ST_DONE;
          else if (op_e'(Op) == OP_SW) next = ST_WRITE;
          else                         next = ST_READ;
        end
      end
      ST_READ:  next = ST_MERGE;
      ST_MERGE: next = ST_DONE;
      ST_WRITE: next = ST_DONE;
      ST_DONE:  next = ST_IDLE;
      default:  next = ST_IDLE;
    endcase
  end

  // Memory strobes come straight from state so a reset drops them at once.
  always_comb begin
    Busy         = (state != ST_IDLE);
    MemAddress   = addr_q[ADDR_WIDTH+1:2];
    MemRead      = (state == ST_READ);
    MemWrite     = (state == ST_WRITE) ||
                   ((state == ST_MERGE) && is_store(op_q));
    MemWriteData = (state == ST_WRITE) ? data_q : merged;
  end

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      op_q     <= OP_LW;
      addr_q   <= '0;
      data_q   <= '0;
      LoadData <= '0;
      Done     <= 1'b0;
      Error    <= 1'b0;
    end else begin
      Done <= (next == ST_DONE);
      if (accept) begin
        op_q   <= op_e'(Op);
        addr_q <= ByteAddr;
        data_q <= StoreData;
        Error  <= bad;
      end
      if ((state == ST_MERGE) && !is_store(op_q))
        LoadData <= ld_ext;
    end
  end

endmodule

// File: tb/tb_mem_access_unit.sv
// Bench for mem_access_unit paired with a behavioural word DataMem;
// results are checked against a word-array reference model.
module tb_mem_access_unit;

  localparam int AW = 10;

  logic          Clock = 1'b0;
  logic          Reset;
  logic          Req;
  logic [2:0]    Op;
  logic [AW+1:0] ByteAddr;
  logic [31:0]   StoreData;
  logic [31:0]   LoadData;
  logic          Busy;
  logic          Done;
  logic          Error;
  logic [AW-1:0] MemAddress;
  logic [31:0]   MemWriteData;
  logic          MemRead;
  logic          MemWrite;
  logic [31:0]   MemReadData;

  mem_access_unit #(.ADDR_WIDTH(AW)) dut (
    .Clock        (Clock),
    .Reset        (Reset),
    .Req          (Req),
    .Op           (Op),
    .ByteAddr     (ByteAddr),
    .StoreData    (StoreData),
    .LoadData     (LoadData),
    .Busy         (Busy),
    .Done         (Done),
    .Error        (Error),
    .MemAddress   (MemAddress),
    .MemWriteData (MemWriteData),
    .MemRead      (MemRead),
    .MemWrite     (MemWrite),
    .MemReadData  (MemReadData)
  );

  always #5 Clock = ~Clock;

  logic [31:0] mem [0:(1<<AW)-1];
  int rd_cnt   = 0;
  int wr_cnt   = 0;
  int both_cnt = 0;

  always @(posedge Clock) begin
    if (MemWrite) mem[MemAddress] <= MemWriteData;
    if (MemRead)  MemReadData <= mem[MemAddress];
    if (MemRead)  rd_cnt <= rd_cnt + 1;
    if (MemWrite) wr_cnt <= wr_cnt + 1;
    if (MemRead && MemWrite) both_cnt <= both_cnt + 1;
  end

  localparam logic [2:0] LW = 3'd0, LH = 3'd1, LHU = 3'd2, LB = 3'd3;
  localparam logic [2:0] LBU = 3'd4, SW = 3'd5, SH = 3'd6, SB = 3'd7;

  logic [31:0] ref_mem [0:31];
  logic [31:0] ref_ld  = 32'h0;
  logic        ref_err = 1'b0;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic run_op(input logic [2:0] op, input logic [11:0] addr,
                        input logic [31:0] sd);
    int idx, off, lat, exp_lat, exp_r, exp_w, rd0, wr0;
    logic mis;
    logic [31:0] w, b, h, m;
    idx = int'(addr[11:2]);
    off = int'(addr[1:0]);
    w   = ref_mem[idx];
    if (op == LW || op == SW)                   mis = (off != 0);
    else if (op == LH || op == LHU || op == SH) mis = (off % 2 != 0);
    else                                        mis = 1'b0;
    b = (w >> (8 * off)) & 32'hFF;
    h = (w >> (16 * (off / 2))) & 32'hFFFF;
    ref_err = mis;
    exp_r = 0; exp_w = 0;
    if (mis) exp_lat = 1;
    else if (op == SW) begin
      exp_lat = 2; exp_w = 1; ref_mem[idx] = sd;
    end else begin
      exp_lat = 3; exp_r = 1;
      case (op)
        LW:  ref_ld = w;
        LH:  ref_ld = h + ((h >= 32'h8000) ? 32'hFFFF0000 : 32'h0);
        LHU: ref_ld = h;
        LB:  ref_ld = b + ((b >= 32'h80) ? 32'hFFFFFF00 : 32'h0);
        LBU: ref_ld = b;
        SH: begin
          exp_w = 1;
          m = 32'hFFFF << (16 * (off / 2));
          ref_mem[idx] = (w & ~m) | ((sd & 32'hFFFF) << (16 * (off / 2)));
        end
        default: begin
          exp_w = 1;
          m = 32'hFF << (8 * off);
          ref_mem[idx] = (w & ~m) | ((sd & 32'hFF) << (8 * off));
        end
      endcase
    end
    @(negedge Clock);
    Req = 1'b1; Op = op; ByteAddr = addr; StoreData = sd;
    rd0 = rd_cnt; wr0 = wr_cnt;
    @(posedge Clock);
    lat = 1;
    #1;
    while (!Done && lat < 8) begin
      Op = 3'($urandom); ByteAddr = 12'($urandom); StoreData = $urandom;
      @(posedge Clock);
      lat++;
      #1;
    end
    Req = 1'b0;
    chk("done_seen", Done, 1'b1);
    chk("latency", lat, exp_lat);
    chk("busy_in_done", Busy, 1'b1);
    chk("error", Error, ref_err);
    chk("load_data", LoadData, ref_ld);
    chk("rd_strobes", rd_cnt - rd0, exp_r);
    chk("wr_strobes", wr_cnt - wr0, exp_w);
    chk("mem_word", mem[idx], ref_mem[idx]);
    chk("quiet_in_done", {MemRead, MemWrite}, 2'b00);
    @(posedge Clock);
    #1;
    chk("done_pulse", {Done, Busy}, 2'b00);
  endtask

  initial begin
    Reset = 1'b1; Req = 1'b0; Op = 3'd0; ByteAddr = '0; StoreData = '0;
    repeat (2) @(posedge Clock);
    #1;
    chk("rst_outs", {LoadData, Done, Error, Busy, MemRead, MemWrite},
        {32'h0, 5'b0});
    @(negedge Clock);
    Reset = 1'b0;

    for (int i = 0; i < 32; i++) run_op(SW, 12'(i * 4), $urandom);

    run_op(SW, 12'h010, 32'hDEADBEEF);
    run_op(LW, 12'h010, 32'h0);
    chk("lw_deadbeef", LoadData, 32'hDEADBEEF);

    run_op(SW, 12'h020, 32'h11223344);
    run_op(SB, 12'h021, 32'h000000AA);
    chk("sb_merge", mem[8], 32'h1122AA44);

    run_op(SW, 12'h030, 32'h80FF7F01);
    run_op(LB, 12'h032, 32'h0);
    chk("lb_sext", LoadData, 32'hFFFFFFFF);
    run_op(LBU, 12'h032, 32'h0);
    chk("lbu_zext", LoadData, 32'h000000FF);
    run_op(LH, 12'h032, 32'h0);
    chk("lh_sext", LoadData, 32'hFFFF80FF);
    run_op(LHU, 12'h030, 32'h0);
    chk("lhu_zext", LoadData, 32'h00007F01);

    run_op(LW, 12'h013, 32'h0);
    chk("lw_mis_err", Error, 1'b1);
    run_op(SH, 12'h031, 32'h5555);
    chk("sh_mis_mem", mem[12], 32'h80FF7F01);

    run_op(SW, 12'h040, 32'hCAFEF00D);
    @(negedge Clock);
    Req = 1'b1; Op = SH; ByteAddr = 12'h040; StoreData = 32'h1234;
    repeat (2) @(posedge Clock);
    #1;
    Req = 1'b0;
    chk("merge_wr", MemWrite, 1'b1);
    Reset = 1'b1;
    #1;
    chk("rst_async", {MemRead, MemWrite, Busy, Done}, 4'b0);
    @(posedge Clock);
    #1;
    chk("rst_mem_kept", mem[16], 32'hCAFEF00D);
    chk("rst_no_done", Done, 1'b0);
    @(negedge Clock);
    Reset = 1'b0;
    ref_ld = 32'h0; ref_err = 1'b0;
    chk("rst_ld_clear", LoadData, 32'h0);

    for (int i = 0; i < 60; i++)
      run_op(3'($urandom_range(0, 7)), 12'($urandom_range(0, 127)), $urandom);

    chk("never_both", both_cnt, 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
